// File: rtl/apb_master_if.sv
// Bundle of command/response handshake and APB bus signals for apb_master.
// The master modport is the initiator's view; slave is the agent+responder side.
interface apb_master_if #(
  parameter int ADDRW = 8,
  parameter int DATAW = 32
);
  // Command channel (agent -> master)
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [ADDRW-1:0] cmd_addr;
  logic [DATAW-1:0] cmd_wdata;

  // Response strobe (master -> agent)
  logic             rsp_valid;
  logic [DATAW-1:0] rsp_rdata;
  logic             rsp_err;
  logic             rsp_timeout;

  // APB bus
  logic [ADDRW-1:0] paddr;
  logic             pwrite;
  logic             psel;
  logic             penable;
  logic [DATAW-1:0] pwdata;
  logic [DATAW-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pwrite, psel, penable, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-requester APB initiator. Accepts one command at a time in IDLE, runs
// a SETUP then ACCESS phase, and reports completion on a one-cycle response
// strobe. An optional watchdog ends ACCESS if pready stays low too long.
module apb_master #(
  parameter int ADDRW   = 8,
  parameter int DATAW   = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  apb_master_if.master bus
);

  // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Wait-edge count at which the next low-pready edge is the TIMEOUT-th one.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam bit              WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             accept;
  logic             done;
  logic             expire;

  logic [CNTW-1:0]  cnt_q;
  logic [ADDRW-1:0] paddr_q;
  logic             pwrite_q;
  logic [DATAW-1:0] pwdata_q;

  logic             rsp_valid_q;
  logic [DATAW-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic             rsp_timeout_q;

  // psel/penable decode straight from the state register, so an async reset
  // drops them in the same instant the state returns to IDLE.
  assign bus.cmd_ready   = (state_q == S_IDLE) && !rst;
  assign bus.psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable     = (state_q == S_ACCESS);
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Next-state and transfer-event decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A ready responder wins over the watchdog on the same edge.
        if (bus.pready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state elements use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all datapath registers are reset too, since the bus and response
    // values must read as zero straight out of reset.
    if (rst) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwrite_q <= bus.cmd_write;
        if (bus.cmd_write) begin
          pwdata_q <= bus.cmd_wdata;
        end
        cnt_q <= '0;
      end else if ((state_q == S_ACCESS) && !bus.pready && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  // Response strobe and held status; data is only sampled on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (done) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
        rsp_err_q     <= bus.pslverr;
        rsp_timeout_q <= 1'b0;
      end else if (expire) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-requester APB initiator: turns a valid/ready command interface into APB SETUP/ACCESS transfers, and returns read data, error and timeout status on a one-cycle response strobe.
- Sits between a register-programming agent (bus bridge or test sequencer) and one or more APB responders sharing psel/penable.
- Handles pready wait states, pslverr, and an optional watchdog timeout so a hung responder cannot stall the agent.

Parameters:
- ADDRW, 8, width of paddr and cmd_addr.
- DATAW, 32, width of pwdata/prdata and command/response data.
- TIMEOUT, 16, max ACCESS cycles with pready low before forced termination; 0 disables the watchdog.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block accepts command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDRW  transfer address.
- cmd_wdata  input  DATAW  write data (ignored for reads).
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATAW  read data (0 for writes and timeouts).
- rsp_err  output  1  pslverr sampled, or timeout.
- rsp_timeout  output  1  transfer ended by watchdog.
- paddr  output  ADDRW  APB address.
- pwrite  output  1  APB direction.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwdata  output  DATAW  APB write data.
- prdata  input  DATAW  APB read data.
- pready  input  1  responder ready; tie high for responders without wait states.
- pslverr  input  1  responder error; tie low if unused.

Behaviour:
- Reset (async, rst=1): state IDLE; psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0; paddr, pwdata and rsp_rdata are 0; watchdog counter is 0. Reset mid-transfer drops psel/penable immediately, and no response is generated.
- cmd_ready = (state == IDLE) and not rst; combinational from state only, with no dependence on cmd_valid.
- States:
  - IDLE:
    - On cmd_valid && cmd_ready: register paddr, pwrite and pwdata (pwdata loaded only for writes, otherwise held), set psel=1, go to SETUP.
  - SETUP (exactly 1 cycle):
    - psel=1, penable=0; next edge sets penable=1 and goes to ACCESS.
  - ACCESS (psel=1, penable=1):
    - Each edge with pready=1: complete. Clear psel/penable and go to IDLE. Next cycle rsp_valid=1, rsp_err=pslverr, rsp_timeout=0, rsp_rdata = (pwrite ? 0 : prdata).
    - Each edge with pready=0: counter increments.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT while pready=0: terminate. Clear psel/penable and go to IDLE. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - pready=1 on the same edge the counter would hit TIMEOUT: normal completion wins.
    - Counter clears on entry to SETUP.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS, and hold their last values in IDLE.
- Minimum transfer latency: accept at edge N → SETUP cycle N+1 → ACCESS cycle N+2 → completion edge → rsp_valid in cycle N+3. cmd_ready is high again in that same cycle, so back-to-back throughput is 1 transfer per 3 cycles.
- Command inputs are ignored outside IDLE.
- prdata and pslverr are sampled only on the completing edge.
- The counter saturates and never wraps. Counter width is clog2(TIMEOUT+1), minimum 1.

Test Plan:
- Write, pready tied 1: cmd write addr 0x04 data 0x0000_02A5 → psel rises 1 cycle after accept, penable 1 cycle later. paddr=0x04, pwrite=1, pwdata=0x2A5 stable. rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: cmd read addr 0x00, pready low for 2 ACCESS cycles, then high with prdata=0x0000_0155 → rsp_rdata=0x155, rsp_err=0, rsp_valid 5 cycles after accept. cmd_ready stays low throughout.
- Slave error: read addr 0x08, pslverr=1 with pready=1 → rsp_err=1, rsp_timeout=0. The next command is accepted in the rsp_valid cycle.
- Timeout with TIMEOUT=4: pready held 0 → psel/penable drop after 4 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0. A follow-up write completes normally.
- Boundary: pready rises on the 4th wait edge (TIMEOUT=4) → normal completion, rsp_timeout=0.
- Reset mid-ACCESS: assert rst during a wait state → psel=penable=0 immediately and no rsp_valid. After release, cmd_ready=1 and a read of 0x00 completes.
